dump_ctrl: RTL and testbench

//  Sequences readback of one captured channel RAM to the host after capture completes.

---
 rtl/dig_pkg.sv | 19 +
 rtl/dump_addr_ctr.sv | 36 +++
 rtl/dump_ctrl.sv | 122 ++++++++++++
 tb/tb_dump_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dig_pkg.sv
// rtl/dig_pkg.sv - shared state encoding and channel limits for the dump sequencer
package dig_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        WAIT,
        FIN
    } dump_state_t;

    localparam logic [2:0] CH_MIN = 3'd1;
    localparam logic [2:0] CH_MAX = 3'd5;

    function automatic logic ch_ok(input logic [2:0] ch);
        return (ch >= CH_MIN) && (ch <= CH_MAX);
    endfunction

endpackage

// File: rtl/dump_addr_ctr.sv
// rtl/dump_addr_ctr.sv - modulo-ENTRIES read address with a sample counter flagging the final byte
module dump_addr_ctr #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld,
    input  logic [LOG2-1:0] ld_addr,
    input  logic            inc,
    output logic [LOG2-1:0] addr,
    output logic            last
);

    localparam logic [LOG2-1:0] ADDR_MAX = LOG2'(ENTRIES - 1);
    localparam logic [LOG2:0]   CNT_MAX  = (LOG2 + 1)'(ENTRIES - 1);

    logic [LOG2:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr  <= '0;
            count <= '0;
        end else if (ld) begin
            addr  <= ld_addr;
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
            // ENTRIES need not be a power of two, so wrap explicitly
            addr  <= (addr == ADDR_MAX) ? '0 : addr + 1'b1;
        end
    end

    assign last = (count == CNT_MAX);

endmodule

// File: rtl/dump_ctrl.sv
// rtl/dump_ctrl.sv - walks one channel RAM oldest-first and hands each byte to the UART
module dump_ctrl
    import dig_pkg::*;
#(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      ch_sel,
    input  logic [LOG2-1:0] start_addr,
    input  logic            abort,
    input  logic [7:0]      rdataCH1,
    input  logic [7:0]      rdataCH2,
    input  logic [7:0]      rdataCH3,
    input  logic [7:0]      rdataCH4,
    input  logic [7:0]      rdataCH5,
    input  logic            resp_sent,
    output logic [LOG2-1:0] raddr,
    output logic [7:0]      resp,
    output logic            send_resp,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [LOG2:0] ENTRIES_W = (LOG2 + 1)'(ENTRIES);

    dump_state_t state;
    logic [2:0]  ch_q;
    logic [7:0]  rdata_sel;
    logic        start_ok;
    logic        ld;
    logic        inc;
    logic        last;

    assign start_ok = ch_ok(ch_sel) && ({1'b0, start_addr} < ENTRIES_W);
    assign ld       = (state == IDLE) && start && start_ok;
    // abort beats a coincident resp_sent, and the final byte leaves raddr on its address
    assign inc      = (state == WAIT) && resp_sent && !abort && !last;

    dump_addr_ctr #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .ld_addr (start_addr),
        .inc     (inc),
        .addr    (raddr),
        .last    (last)
    );

    always_comb begin
        rdata_sel = 8'h00;
        case (ch_q)
            3'd1:    rdata_sel = rdataCH1;
            3'd2:    rdata_sel = rdataCH2;
            3'd3:    rdata_sel = rdataCH3;
            3'd4:    rdata_sel = rdataCH4;
            3'd5:    rdata_sel = rdataCH5;
            default: rdata_sel = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ch_q      <= 3'd0;
            resp      <= 8'h00;
            send_resp <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            send_resp <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            if (state != IDLE && abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (start_ok) begin
                                ch_q  <= ch_sel;
                                state <= READ;
                                busy  <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    READ: state <= LOAD;
                    LOAD: begin
                        resp      <= rdata_sel;
                        send_resp <= 1'b1;
                        state     <= WAIT;
                    end
                    WAIT: begin
                        if (resp_sent) begin
                            state <= last ? FIN : READ;
                        end
                    end
                    FIN: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dump_ctrl.sv
// tb/tb_dump_ctrl.sv - self-checking bench for dump_ctrl with RAM models and a byte scoreboard
module tb_dump_ctrl;

    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      ch_sel;
    logic [LOG2-1:0] start_addr;
    logic            abort;
    logic [7:0]      rdataCH1, rdataCH2, rdataCH3, rdataCH4, rdataCH5;
    logic            resp_sent;
    logic [LOG2-1:0] raddr;
    logic [7:0]      resp;
    logic            send_resp, busy, done, err;

    always #5 clk = ~clk;

    dump_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ch_sel     (ch_sel),
        .start_addr (start_addr),
        .abort      (abort),
        .rdataCH1   (rdataCH1),
        .rdataCH2   (rdataCH2),
        .rdataCH3   (rdataCH3),
        .rdataCH4   (rdataCH4),
        .rdataCH5   (rdataCH5),
        .resp_sent  (resp_sent),
        .raddr      (raddr),
        .resp       (resp),
        .send_resp  (send_resp),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    logic [7:0] ram [1:5][0:ENTRIES-1];

    always @(posedge clk) begin
        rdataCH1 <= ram[1][raddr];
        rdataCH2 <= ram[2][raddr];
        rdataCH3 <= ram[3][raddr];
        rdataCH4 <= ram[4][raddr];
        rdataCH5 <= ram[5][raddr];
    end

    typedef struct {
        logic [LOG2-1:0] addr;
        logic [7:0]      data;
    } exp_t;

    typedef struct {
        logic [2:0]      ch;
        logic [LOG2-1:0] addr;
        logic            exp_err;
        logic            exp_busy;
    } vec_t;

    exp_t            exp_q[$];
    int              errors = 0;
    int              checks = 0;
    logic [LOG2-1:0] exp_raddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic run_dump(input int ch, input int addr, input int abort_at, input int busy_start_at);
        int   w;
        int   stray;
        exp_t e;
        for (int i = 0; i < ENTRIES; i++) begin
            e.addr = LOG2'((addr + i) % ENTRIES);
            e.data = ram[ch][(addr + i) % ENTRIES];
            exp_q.push_back(e);
        end
        ch_sel     = 3'(ch);
        start_addr = LOG2'(addr);
        start      = 1'b1;
        tick();
        start      = 1'b0;
        ch_sel     = 3'd5;
        start_addr = LOG2'(7);
        for (int n = 0; n < ENTRIES; n++) begin
            w = 0;
            while (!send_resp && w < 20) begin
                tick();
                w++;
            end
            if (!send_resp) begin
                chk("send_resp_timeout", 0, 1);
                exp_q.delete();
                return;
            end
            if (n < 2) chk("send_resp_latency", w, 2);
            e = exp_q.pop_front();
            chk("resp_data", resp, e.data);
            chk("resp_addr", raddr, e.addr);
            if (n == busy_start_at) begin
                ch_sel     = 3'd5;
                start_addr = '0;
                start      = 1'b1;
            end
            tick();
            start = 1'b0;
            if (n == 0) chk("send_resp_pulse", send_resp, 0);
            if (n == busy_start_at) begin
                chk("err_on_busy_start", err, 0);
                chk("busy_on_busy_start", busy, 1);
            end
            if (n == abort_at) begin
                abort     = 1'b1;
                resp_sent = 1'b1;
                tick();
                abort     = 1'b0;
                resp_sent = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_send_resp", send_resp, 0);
                chk("abort_raddr_held", raddr, e.addr);
                chk("abort_resp_held", resp, e.data);
                stray = 0;
                for (int k = 0; k < 8; k++) begin
                    tick();
                    if (done || send_resp || busy) stray++;
                end
                chk("abort_no_activity", stray, 0);
                exp_q.delete();
                exp_raddr = e.addr;
                return;
            end
            tick();
            resp_sent = 1'b1;
            tick();
            resp_sent = 1'b0;
        end
        w = 0;
        while (!done && w < 10) begin
            tick();
            w++;
        end
        chk("done_seen", done, 1);
        chk("done_latency", w, 1);
        chk("done_busy", busy, 0);
        chk("done_no_send", send_resp, 0);
        exp_raddr = LOG2'((addr + ENTRIES - 1) % ENTRIES);
        chk("final_raddr", raddr, exp_raddr);
        tick();
        chk("done_pulse", done, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int   w;
        int   stray;

        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ram[k][i] = (k == 3) ? 8'(i) : 8'(i * k + 31 * k);
            end
        end

        vecs[0] = '{3'd0, LOG2'(0),   1'b1, 1'b0};
        vecs[1] = '{3'd6, LOG2'(0),   1'b1, 1'b0};
        vecs[2] = '{3'd7, LOG2'(5),   1'b1, 1'b0};
        vecs[3] = '{3'd3, LOG2'(384), 1'b1, 1'b0};
        vecs[4] = '{3'd1, LOG2'(383), 1'b0, 1'b1};

        rst        = 1'b1;
        start      = 1'b0;
        ch_sel     = 3'd0;
        start_addr = '0;
        abort      = 1'b0;
        resp_sent  = 1'b0;
        tick();
        tick();
        chk("reset_raddr", raddr, 0);
        chk("reset_resp", resp, 0);
        chk("reset_send_resp", send_resp, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        rst = 1'b0;
        exp_raddr = '0;
        tick();

        foreach (vecs[i]) begin
            ch_sel     = vecs[i].ch;
            start_addr = vecs[i].addr;
            start      = 1'b1;
            tick();
            start = 1'b0;
            chk("vec_err", err, vecs[i].exp_err);
            chk("vec_busy", busy, vecs[i].exp_busy);
            if (!vecs[i].exp_busy) chk("vec_raddr_unchanged", raddr, exp_raddr);
            tick();
            chk("vec_err_pulse", err, 0);
            chk("vec_no_send", send_resp, 0);
            if (vecs[i].exp_busy) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("vec_abort_busy", busy, 0);
                chk("vec_abort_no_send", send_resp, 0);
                exp_raddr = vecs[i].addr;
                chk("vec_abort_raddr", raddr, exp_raddr);
            end
            tick();
        end

        run_dump(3, 0, -1, 10);
        tick();
        run_dump(3, 380, -1, -1);
        tick();

        ch_sel     = 3'd2;
        start_addr = LOG2'(10);
        start      = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (!send_resp && w < 20) begin
            tick();
            w++;
        end
        chk("rst_test_send_seen", send_resp, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_raddr", raddr, 0);
        chk("midrst_resp", resp, 0);
        chk("midrst_send_resp", send_resp, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done || send_resp || busy) stray++;
        end
        chk("midrst_no_activity", stray, 0);
        exp_raddr = '0;

        run_dump(1, 100, 3, -1);
        tick();
        run_dump(2, 5, -1, -1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
